// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths, latency constant and the
// round-half-up / saturate helper used at the complex multiplier output.
package fft_pkg;

   localparam int FFT_A_W        = 16;
   localparam int FFT_B_W        = 16;
   localparam int FFT_OUT_W      = 16;
   localparam int FFT_SHIFT      = 14;
   localparam int FFT_PIPE_LEVEL = 1;

   // Twiddles are Q1.(B_W-2): +1.0 is 2^(B_W-2), so the full range stays representable.
   localparam int TWIDDLE_FRAC   = FFT_B_W - 2;

   // S0 input register + PIPE_LEVEL product stages + combine + output register.
   localparam int CMULT_LAT      = FFT_PIPE_LEVEL + 3;

   // Working width for round_sat; wide enough for any legal A_W+B_W+1 sum.
   localparam int RS_W           = 64;

   typedef struct packed {
      logic                   sat;
      logic signed [RS_W-1:0] val;
   } rs_t;

   function automatic int cmult_lat(input int pipe_level);
      return pipe_level + 32'sd3;
   endfunction

   // Round half up by adding 2^(shift-1) before an arithmetic right shift,
   // then clip to the signed out_w range and flag whether clipping happened.
   function automatic rs_t round_sat(input logic signed [RS_W-1:0] x,
                                     input int                     shift,
                                     input int                     out_w);
      logic signed [RS_W-1:0] acc_s;
      logic signed [RS_W-1:0] max_s;
      logic signed [RS_W-1:0] min_s;
      rs_t                    res_s;
      if (shift > 32'sd0) begin
         acc_s = x + (64'sd1 <<< (shift - 32'sd1));
      end else begin
         acc_s = x;
      end
      acc_s = acc_s >>> shift;
      max_s = (64'sd1 <<< (out_w - 32'sd1)) - 64'sd1;
      min_s = -(64'sd1 <<< (out_w - 32'sd1));
      if (acc_s > max_s) begin
         res_s.sat = 1'b1;
         res_s.val = max_s;
      end else if (acc_s < min_s) begin
         res_s.sat = 1'b1;
         res_s.val = min_s;
      end else begin
         res_s.sat = 1'b0;
         res_s.val = acc_s;
      end
      return res_s;
   endfunction

endpackage

// File: rtl/smul_pipe.sv
// Signed real multiplier with a PIPE_LEVEL-deep output pipeline, stalled by en.
module smul_pipe
   import fft_pkg::*;
#(
   parameter int A_W        = FFT_A_W,
   parameter int B_W        = FFT_B_W,
   parameter int PIPE_LEVEL = FFT_PIPE_LEVEL
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic signed [A_W-1:0]   a_i,
   input  logic signed [B_W-1:0]   b_i,
   output logic signed [A_W+B_W-1:0] p_o
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0] prod_d;
   logic signed [P_W-1:0] stage_q [PIPE_LEVEL];

   // Full-precision product: both operands are sign-extended first so nothing wraps.
   always_comb begin
      prod_d = P_W'(a_i) * P_W'(b_i);
   end

   // Product pipeline; stage 0 takes the fresh product, later stages shift it along.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_LEVEL; i++) begin
            stage_q[i] <= '0;
         end
      end else if (en) begin
         stage_q[0] <= prod_d;
         for (int i = 1; i < PIPE_LEVEL; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign p_o = stage_q[PIPE_LEVEL-1];

endmodule

// File: rtl/cmult_pipe.sv
// Pipelined complex multiplier y = a * w (or a * conj(w)) with round-half-up
// rescaling, saturation, valid sideband and a global stall enable.
module cmult_pipe
   import fft_pkg::*;
#(
   parameter int A_W        = FFT_A_W,
   parameter int B_W        = FFT_B_W,
   parameter int OUT_W      = FFT_OUT_W,
   parameter int SHIFT      = FFT_SHIFT,
   parameter int PIPE_LEVEL = FFT_PIPE_LEVEL
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic                    conj,
   input  logic signed [A_W-1:0]   a_re,
   input  logic signed [A_W-1:0]   a_im,
   input  logic signed [B_W-1:0]   w_re,
   input  logic signed [B_W-1:0]   w_im,
   input  logic                    clr,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] y_re,
   output logic signed [OUT_W-1:0] y_im,
   output logic                    sat,
   output logic                    sat_sticky
);

   localparam int P_W = A_W + B_W;
   // One extra bit so the sum of two extreme products never wraps.
   localparam int S_W = P_W + 1;
   localparam int L   = cmult_lat(PIPE_LEVEL);

   logic signed [A_W-1:0]   a_re_q, a_im_q;
   logic signed [B_W-1:0]   w_re_q, w_im_q;
   logic [L-1:0]            valid_q;
   logic [PIPE_LEVEL:0]     conj_q;

   logic signed [P_W-1:0]   p_rr_s, p_ii_s, p_ir_s, p_ri_s;
   logic signed [S_W-1:0]   sum_re_d, sum_im_d;
   logic signed [S_W-1:0]   sum_re_q, sum_im_q;

   rs_t                     rs_re_s, rs_im_s;
   logic signed [OUT_W-1:0] y_re_d, y_im_d;
   logic                    sat_d, set_s;
   logic signed [OUT_W-1:0] y_re_q, y_im_q;
   logic                    sat_q;
   logic                    sat_sticky_d, sat_sticky_q;

   // S0: capture operands; data loads whether or not the sample is valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_re_q <= '0;
         a_im_q <= '0;
         w_re_q <= '0;
         w_im_q <= '0;
      end else if (en) begin
         a_re_q <= a_re;
         a_im_q <= a_im;
         w_re_q <= w_re;
         w_im_q <= w_im;
      end
   end

   // Valid and conj sideband shift registers, kept aligned with the datapath.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         conj_q  <= '0;
      end else if (en) begin
         valid_q <= {valid_q[L-2:0], in_valid};
         conj_q  <= {conj_q[PIPE_LEVEL-1:0], conj};
      end
   end

   smul_pipe #(.A_W(A_W), .B_W(B_W), .PIPE_LEVEL(PIPE_LEVEL)) u_mul_rr (
      .clk(clk), .rst_n(rst_n), .en(en), .a_i(a_re_q), .b_i(w_re_q), .p_o(p_rr_s));
   smul_pipe #(.A_W(A_W), .B_W(B_W), .PIPE_LEVEL(PIPE_LEVEL)) u_mul_ii (
      .clk(clk), .rst_n(rst_n), .en(en), .a_i(a_im_q), .b_i(w_im_q), .p_o(p_ii_s));
   smul_pipe #(.A_W(A_W), .B_W(B_W), .PIPE_LEVEL(PIPE_LEVEL)) u_mul_ir (
      .clk(clk), .rst_n(rst_n), .en(en), .a_i(a_im_q), .b_i(w_re_q), .p_o(p_ir_s));
   smul_pipe #(.A_W(A_W), .B_W(B_W), .PIPE_LEVEL(PIPE_LEVEL)) u_mul_ri (
      .clk(clk), .rst_n(rst_n), .en(en), .a_i(a_re_q), .b_i(w_im_q), .p_o(p_ri_s));

   // Combine the four products; conjugate mode flips the sign of every w_im term.
   always_comb begin
      sum_re_d = '0;
      sum_im_d = '0;
      if (conj_q[PIPE_LEVEL]) begin
         sum_re_d = S_W'(p_rr_s) + S_W'(p_ii_s);
         sum_im_d = S_W'(p_ir_s) - S_W'(p_ri_s);
      end else begin
         sum_re_d = S_W'(p_rr_s) - S_W'(p_ii_s);
         sum_im_d = S_W'(p_ir_s) + S_W'(p_ri_s);
      end
   end

   // Combine-stage register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_re_q <= '0;
         sum_im_q <= '0;
      end else if (en) begin
         sum_re_q <= sum_re_d;
         sum_im_q <= sum_im_d;
      end
   end

   // Rescale and clip both components; sat flags a clip on either one.
   always_comb begin
      rs_re_s = round_sat(RS_W'(sum_re_q), SHIFT, OUT_W);
      rs_im_s = round_sat(RS_W'(sum_im_q), SHIFT, OUT_W);
      y_re_d  = OUT_W'(rs_re_s.val);
      y_im_d  = OUT_W'(rs_im_s.val);
      sat_d   = rs_re_s.sat | rs_im_s.sat;
   end

   // Sticky flag next state: a new valid saturating result beats a same-cycle clear.
   always_comb begin
      set_s = en & valid_q[L-2] & sat_d;
      if (set_s) begin
         sat_sticky_d = 1'b1;
      end else if (clr) begin
         sat_sticky_d = 1'b0;
      end else begin
         sat_sticky_d = sat_sticky_q;
      end
   end

   // Output register stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_re_q <= '0;
         y_im_q <= '0;
         sat_q  <= 1'b0;
      end else if (en) begin
         y_re_q <= y_re_d;
         y_im_q <= y_im_d;
         sat_q  <= sat_d;
      end
   end

   // Sticky saturation register; clr is honoured even while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_sticky_q <= 1'b0;
      end else begin
         sat_sticky_q <= sat_sticky_d;
      end
   end

   assign out_valid  = valid_q[L-1];
   assign y_re       = y_re_q;
   assign y_im       = y_im_q;
   assign sat        = sat_q;
   assign sat_sticky = sat_sticky_q;

endmodule

// File: doc/cmult_pipe.md
Name: cmult_pipe

Overview:
- Parametrised pipelined complex multiplier for the FFT datapath. It computes data × twiddle, for example at the radix-2 butterfly outputs of the 64-point FFT.
- It generalises the single real pipelined multiplier with:
  - complex operands and a conjugate mode for the IFFT;
  - round-half-up rescaling and saturation;
  - a valid sideband and a global stall enable.
- It sits between the butterfly adder stage and the next stage's input registers.

Parameters:
- A_W, 16, data input width per component (signed)
- B_W, 16, twiddle width per component (signed, Q1.(B_W-2))
- OUT_W, 16, output width per component (signed)
- SHIFT, 14, arithmetic right shift applied after accumulation; 0 ≤ SHIFT < A_W+B_W
- PIPE_LEVEL, 1, pipeline stages inside each real multiplier; must be ≥ 1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  global clock enable; 0 freezes every stage
- in_valid  in  1  input sample valid
- conj  in  1  1: use conj(w); sampled with data
- a_re, a_im  in  A_W each  data operand
- w_re, w_im  in  B_W each  twiddle operand
- out_valid  out  1  result valid
- y_re, y_im  out  OUT_W each  result
- sat  out  1  this result was clipped (either component)
- sat_sticky  out  1  OR of all sat since reset or clr
- clr  in  1  clears sat_sticky (synchronous)

Behaviour:
- Reset: while rst_n=0 at a clk edge, every pipeline register is cleared, including data, valid and conj. Outputs read out_valid=0, y_re=y_im=0, sat=0, sat_sticky=0.
  - Reset mid-stream discards every in-flight sample.
  - Reset has priority over en and clr.
- Stall: en=0 holds every register, valid bits and sat_sticky included. clr is still honoured when en=0.
- Pipeline, all stages gated by en, total latency L = PIPE_LEVEL+3 enabled cycles:
  - S0: register a, w, conj, in_valid.
  - S1..S(PIPE_LEVEL): four real products a_re*w_re, a_im*w_im, a_im*w_re, a_re*w_im. Each is A_W+B_W bits, all in parallel.
  - S(PIPE_LEVEL+1): combine at A_W+B_W+1 bits. When conj=1 the signs of the w_im terms are negated.
    - conj=0: re = ar*wr − ai*wi, im = ai*wr + ar*wi
    - conj=1: re = ar*wr + ai*wi, im = ai*wr − ar*wi
  - S(PIPE_LEVEL+2), the output register:
    - Round: add 2^(SHIFT−1) (skip when SHIFT=0), then arithmetic shift right by SHIFT. This is round-half-up, so −1.5 gives −1.
    - Saturate: clip to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
    - sat = 1 if either component clipped.
- Full throughput: one sample per enabled cycle, with no bubbles between back-to-back samples.
- Valid semantics: in_valid rides with the data. Data regs load regardless of valid, so y holds garbage-but-deterministic values when out_valid=0.
- sat_sticky updates only on cycles where out_valid=1 and sat=1. When clr=1 on the same edge, clr wins for the clear, but a simultaneous new sat sets the bit again, so set has priority over clear.
- Width rule: the sum register needs A_W+B_W+1 bits, because the worst case is ±2^(A_W+B_W−1) plus the rounding constant. No intermediate wrap is permitted.

Decomposition:
- Shared package fft_pkg: default widths A_W/B_W/OUT_W, TWIDDLE_FRAC = B_W−2, a round_sat function (round-half-up plus clip, parametrised on width and shift), and a latency constant CMULT_LAT = PIPE_LEVEL+3.
- One sub-module, smul_pipe: signed real multiplier with en, PIPE_LEVEL stages and synchronous active-low reset. Instantiate it four times.
- The valid/conj sideband is a plain shift register in the top level.

Test Plan (all scenarios use the defaults, L=4):
- Identity: a=(1000,0), w=(16384,0), conj=0 → after 4 cycles y=(1000,0), out_valid=1, sat=0.
- Rotation: a=(1000,2000), w=(0,16384) → y=(−2000,1000). Same sample with conj=1 → y=(2000,−1000).
- Rounding: a=(3,0), w=(8192,0) → y_re=2. a=(−3,0), same w → y_re=−1. a=(1,0), w=(8191,0) → y_re=0.
- Saturation:
  - a=(−32768,−32768), w=(16384,−16384) → y=(−32768,0), sat=1, sat_sticky=1.
  - Then pulse clr with no new sat → sat_sticky=0.
  - Then clr together with a saturating output → sat_sticky stays 1.
- Stall and throughput:
  - Stream 8 back-to-back samples and hold en=0 for 3 cycles mid-stream → all 8 emerge in order, with the output frozen during the stall.
  - Total valid count is 8; each result is checked against a reference model.
- Reset mid-operation: drive rst_n=0 for 1 cycle while 3 samples are in flight → out_valid stays 0 for the next 4 cycles and y=(0,0). A sample entered after reset emerges at exactly L.
